ctrl_pipe_chain: RTL and testbench

- Parametrised control-signal pipeline: carries a decoded control bundle from decode through STAGES back-end pipeline registers, each with its own stall and flush.
- Successor to the fixed hand-wired E/M/W control registers.
- Adds per-stage valid tracking, automatic upstream stall propagation and automatic bubble insertion below a stalled stage.
- Sits between the main/ALU decoders and the datapath hazard unit.

---
 rtl/ctrl_pipe_chain.sv | 88 ++++++++
 tb/tb_ctrl_pipe_chain.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_chain.sv
// Control-bundle pipeline: STAGES registers with per-stage stall/flush, valid tracking,
// upstream stall propagation and bubble insertion. Define CTRL_PIPE_PERF_EN for stall/flush counters.
module ctrl_pipe_chain #(
  parameter int WIDTH = 32,
  parameter int STAGES = 3,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    in_valid,
  input  logic [STAGES-1:0]       stall,
  input  logic [STAGES-1:0]       flush,
  output logic [STAGES*WIDTH-1:0] out_data,
  output logic [STAGES-1:0]       out_valid,
  output logic [STAGES-1:0]       stall_eff,
`ifdef CTRL_PIPE_PERF_EN
  input  logic                    perf_clr,
  output logic [31:0]             perf_stall_cnt,
  output logic [31:0]             perf_flush_cnt,
`endif
  output logic                    in_ready
);

  logic [WIDTH-1:0]  dataReg [STAGES];
  logic [STAGES-1:0] validReg;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : gStage
      // OR-reduce the stall requests at and above this stage (no combinational chain)
      assign stall_eff[gi] = |stall[STAGES-1:gi];
      assign out_data[gi*WIDTH +: WIDTH] = dataReg[gi];

      if (gi == 0) begin : gHead
        always_ff @(posedge clk) begin
          if (rst || flush[gi]) begin
            dataReg[gi]  <= NOP_VALUE;
            validReg[gi] <= 1'b0;
          end else if (!stall_eff[gi]) begin
            dataReg[gi]  <= in_valid ? in_data : NOP_VALUE;
            validReg[gi] <= in_valid;
          end
        end
      end else begin : gBody
        always_ff @(posedge clk) begin
          if (rst || flush[gi]) begin
            dataReg[gi]  <= NOP_VALUE;
            validReg[gi] <= 1'b0;
          end else if (stall_eff[gi]) begin
            dataReg[gi]  <= dataReg[gi];
            validReg[gi] <= validReg[gi];
          end else if (stall_eff[gi-1]) begin
            // upstream is frozen: emit a bubble so its entry is not duplicated here
            dataReg[gi]  <= NOP_VALUE;
            validReg[gi] <= 1'b0;
          end else begin
            dataReg[gi]  <= dataReg[gi-1];
            validReg[gi] <= validReg[gi-1];
          end
        end
      end
    end
  endgenerate

  assign out_valid = validReg;
  assign in_ready  = ~stall_eff[0];

`ifdef CTRL_PIPE_PERF_EN
  logic [31:0] stallCntReg;
  logic [31:0] flushCntReg;

  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      stallCntReg <= '0;
      flushCntReg <= '0;
    end else begin
      if (stall_eff[0]) stallCntReg <= stallCntReg + 32'd1;
      // only count flushes that actually discarded a real instruction
      if (|(flush & validReg)) flushCntReg <= flushCntReg + 32'd1;
    end
  end

  assign perf_stall_cnt = stallCntReg;
  assign perf_flush_cnt = flushCntReg;
`endif

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Directed bench for ctrl_pipe_chain (WIDTH=8, STAGES=3); perf test only when CTRL_PIPE_PERF_EN is defined.
module tb_ctrl_pipe_chain;
  localparam int WIDTH = 8;
  localparam int STAGES = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [WIDTH-1:0]        in_data;
  logic                    in_valid;
  logic [STAGES-1:0]       stall;
  logic [STAGES-1:0]       flush;
  logic [STAGES*WIDTH-1:0] out_data;
  logic [STAGES-1:0]       out_valid;
  logic [STAGES-1:0]       stall_eff;
  logic                    in_ready;
`ifdef CTRL_PIPE_PERF_EN
  logic                    perf_clr;
  logic [31:0]             perf_stall_cnt;
  logic [31:0]             perf_flush_cnt;
`endif

  int nChecks = 0;
  int nFails = 0;

  ctrl_pipe_chain #(.WIDTH(WIDTH), .STAGES(STAGES), .NOP_VALUE(8'h00)) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .stall(stall),
    .flush(flush),
    .out_data(out_data),
    .out_valid(out_valid),
    .stall_eff(stall_eff),
`ifdef CTRL_PIPE_PERF_EN
    .perf_clr(perf_clr),
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt),
`endif
    .in_ready(in_ready)
  );

  always #5 clk = ~clk;

  // one rising edge, then settle 1 time unit so outputs are sampled away from the edge
  task automatic step();
    @(posedge clk);
    #1;
    $display("txn: rst=%b in=%h v=%b stall=%b flush=%b -> data=%h valid=%b",
             rst, in_data, in_valid, stall, flush, out_data, out_valid);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_data = 8'hAA; in_valid = 1'b1; stall = '0; flush = '0;
`ifdef CTRL_PIPE_PERF_EN
    perf_clr = 1'b0;
`endif
    step(); step();
    rst = 1'b0; in_valid = 1'b0;
    nChecks++;
    if (out_data !== 24'h000000) begin nFails++; $display("FAIL reset_data got=%h exp=%h", out_data, 24'h000000); end
    nChecks++;
    if (out_valid !== 3'b000) begin nFails++; $display("FAIL reset_valid got=%b exp=%b", out_valid, 3'b000); end
    nChecks++;
    if (in_ready !== 1'b1) begin nFails++; $display("FAIL reset_ready got=%b exp=%b", in_ready, 1'b1); end
  endtask

  // leaves s0=33 s1=22 s2=11 for the back-stall test
  task automatic test_flow();
    in_valid = 1'b1;
    in_data = 8'h11; step();
    nChecks++;
    if (out_data !== 24'h000011 || out_valid !== 3'b001) begin nFails++;
      $display("FAIL flow_e1 got=%h/%b exp=%h/%b", out_data, out_valid, 24'h000011, 3'b001); end
    in_data = 8'h22; step();
    nChecks++;
    if (out_data !== 24'h001122 || out_valid !== 3'b011) begin nFails++;
      $display("FAIL flow_e2 got=%h/%b exp=%h/%b", out_data, out_valid, 24'h001122, 3'b011); end
    in_data = 8'h33; step();
    nChecks++;
    if (out_data !== 24'h112233 || out_valid !== 3'b111) begin nFails++;
      $display("FAIL flow_e3 got=%h/%b exp=%h/%b", out_data, out_valid, 24'h112233, 3'b111); end
  endtask

  task automatic test_back_stall();
    in_data = 8'h44; in_valid = 1'b1; stall = 3'b010;
    #1;
    nChecks++;
    if (stall_eff !== 3'b011) begin nFails++; $display("FAIL bstall_eff got=%b exp=%b", stall_eff, 3'b011); end
    nChecks++;
    if (in_ready !== 1'b0) begin nFails++; $display("FAIL bstall_ready got=%b exp=%b", in_ready, 1'b0); end
    for (int i = 0; i < 2; i++) begin
      step();
      nChecks++;
      if (out_data !== 24'h002233 || out_valid !== 3'b011) begin nFails++;
        $display("FAIL bstall_hold%0d got=%h/%b exp=%h/%b", i, out_data, out_valid, 24'h002233, 3'b011); end
      nChecks++;
      if (in_ready !== 1'b0) begin nFails++; $display("FAIL bstall_ready%0d got=%b exp=%b", i, in_ready, 1'b0); end
    end
    stall = 3'b000;
    step();
    nChecks++;
    if (out_data !== 24'h223344 || out_valid !== 3'b111) begin nFails++;
      $display("FAIL bstall_release got=%h/%b exp=%h/%b", out_data, out_valid, 24'h223344, 3'b111); end
  endtask

  task automatic test_flush_vs_stall();
    rst = 1'b1; step(); rst = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h22; step();
    in_data = 8'h55; step();
    nChecks++;
    if (out_data !== 24'h002255 || out_valid !== 3'b011) begin nFails++;
      $display("FAIL fvs_setup got=%h/%b exp=%h/%b", out_data, out_valid, 24'h002255, 3'b011); end
    in_data = 8'h66; flush = 3'b010; stall = 3'b010;
    step();
    nChecks++;
    if (out_data !== 24'h000055 || out_valid !== 3'b001) begin nFails++;
      $display("FAIL fvs_result got=%h/%b exp=%h/%b", out_data, out_valid, 24'h000055, 3'b001); end
    flush = 3'b000; stall = 3'b000;
  endtask

  task automatic test_decode_bubble();
    in_data = 8'hFF; in_valid = 1'b0;
    step();
    nChecks++;
    if (out_data !== 24'h005500 || out_valid !== 3'b010) begin nFails++;
      $display("FAIL bubble got=%h/%b exp=%h/%b", out_data, out_valid, 24'h005500, 3'b010); end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1;
    in_data = 8'hA1; step();
    in_data = 8'hA2; step();
    in_data = 8'hA3; step();
    nChecks++;
    if (out_data !== 24'hA1A2A3 || out_valid !== 3'b111) begin nFails++;
      $display("FAIL rmid_full got=%h/%b exp=%h/%b", out_data, out_valid, 24'hA1A2A3, 3'b111); end
    stall = 3'b100; flush = 3'b000; rst = 1'b1; in_data = 8'hA4;
    step();
    nChecks++;
    if (out_data !== 24'h000000 || out_valid !== 3'b000) begin nFails++;
      $display("FAIL rmid_clear got=%h/%b exp=%h/%b", out_data, out_valid, 24'h000000, 3'b000); end
    rst = 1'b0; stall = 3'b000; in_data = 8'hB1;
    step();
    nChecks++;
    if (out_data !== 24'h0000B1 || out_valid !== 3'b001) begin nFails++;
      $display("FAIL rmid_resume got=%h/%b exp=%h/%b", out_data, out_valid, 24'h0000B1, 3'b001); end
  endtask

  // flush of stage 0 with stall of stage 1: stage 0 clears, stage 1 holds, stage 2 bubbles
  task automatic test_back_to_back();
    in_data = 8'hB2; step();
    nChecks++;
    if (out_data !== 24'h00B1B2 || out_valid !== 3'b011) begin nFails++;
      $display("FAIL b2b_setup got=%h/%b exp=%h/%b", out_data, out_valid, 24'h00B1B2, 3'b011); end
    in_data = 8'hB3; flush = 3'b001; stall = 3'b010;
    step();
    nChecks++;
    if (out_data !== 24'h00B100 || out_valid !== 3'b010) begin nFails++;
      $display("FAIL b2b_flush_stall got=%h/%b exp=%h/%b", out_data, out_valid, 24'h00B100, 3'b010); end
    flush = 3'b000; stall = 3'b000;
  endtask

`ifdef CTRL_PIPE_PERF_EN
  task automatic test_perf();
    rst = 1'b1; step(); rst = 1'b0;
    in_data = 8'h77; in_valid = 1'b1; step();
    in_valid = 1'b0; stall = 3'b001;
    for (int i = 0; i < 5; i++) step();
    stall = 3'b000; flush = 3'b001;
    step();
    flush = 3'b000;
    nChecks++;
    if (perf_stall_cnt !== 32'd5) begin nFails++; $display("FAIL perf_stall got=%0d exp=%0d", perf_stall_cnt, 5); end
    nChecks++;
    if (perf_flush_cnt !== 32'd1) begin nFails++; $display("FAIL perf_flush got=%0d exp=%0d", perf_flush_cnt, 1); end
    perf_clr = 1'b1; stall = 3'b001; step(); perf_clr = 1'b0; stall = 3'b000;
    nChecks++;
    if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin nFails++;
      $display("FAIL perf_clr got=%0d/%0d exp=0/0", perf_stall_cnt, perf_flush_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_flow();
    test_back_stall();
    test_flush_vs_stall();
    test_decode_bubble();
    test_reset_mid();
    test_back_to_back();
`ifdef CTRL_PIPE_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
